q_cycle_sequencer: RTL
======================

# q_cycle_sequencer

Instruction-cycle sequencer for the midrange PIC core. It divides each instruction cycle into four clock phases (Q1–Q4) and issues the fetch, PC-increment, register-read and register-write strobes that drive the program memory, program counter and register file. It inserts forced-NOP (flush) cycles after taken branches, stretches Q2 for slow external peripherals with a bounded wait, and implements SLEEP/wake. It sits between the instruction decoder (branch/sleep requests) and the datapath enables.

## Interface
Parameters:
- RESET_HOLD_CLKS, 8: clocks held idle after reset release before the first flush cycle; legal range 1..255.
- WAIT_MAX, 7: maximum extra Q2 clocks per instruction cycle granted to `periph_wait`; legal range 1..255.

Ports:
- clk  in  1  core clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- branch_req  in  1  taken branch/skip; sampled on the edge ending Q3 of a RUN cycle.
- sleep_req  in  1  SLEEP executed; sampled on the edge ending Q4 of a RUN cycle.
- wake  in  1  wake event (level); sampled only in SLEEP.
- periph_wait  in  1  external peripheral not ready; sampled only in Q2 of a RUN cycle.
- q_phase  out  2  current phase: 0=Q1, 1=Q2, 2=Q3, 3=Q4.
- exec_valid  out  1  high for all clocks of a RUN cycle.
- rd_strobe  out  1  high for every clock of Q2 in RUN, including stall clocks.
- wr_strobe  out  1  high in Q4 of RUN.
- instr_rd_en  out  1  high in Q4 of RUN or FLUSH (fetch next word).
- pc_incr_en  out  1  high in Q4 of RUN or FLUSH.
- instr_flush  out  1  high in Q4 of a RUN cycle whose branch was taken.
- sleeping  out  1  high while in SLEEP.
- bus_timeout  out  1  sticky; set when a wait expires; cleared only by reset.
- retired_count  out  16  count of completed RUN cycles; wraps 0xFFFF→0x0000.

## Operation
- The registered state is: `state` ∈ {HOLD, RUN, FLUSH, SLEEP}, the 2-bit `q` counter, the hold counter, the wait counter, the `br_pending` and `bus_timeout` flags, and `retired_count`. All outputs are decoded combinationally from this registered state only. No output has a combinational path from an input.
- Reset values: state=HOLD, q=0, hold counter=RESET_HOLD_CLKS, wait counter=0, br_pending=0, bus_timeout=0, retired_count=0.
  - Resulting outputs: q_phase=0, sleeping=0, and every strobe and enable low.
- HOLD: `q` frozen at 0. The hold counter decrements each clock. On the edge where it reaches 0, the block enters FLUSH with q=0.
- RUN/FLUSH: `q` advances by 1 each clock and wraps 3→0, except during a Q2 stall.
- Q2 stall (RUN only): while in Q2 with periph_wait=1 and wait counter < WAIT_MAX, `q` holds and the wait counter increments.
  - If periph_wait=1 and wait counter = WAIT_MAX, `q` advances to Q3 anyway and bus_timeout is set.
  - The wait counter clears on leaving Q2.
- On the edge ending Q3 of RUN, `br_pending` is loaded from branch_req. instr_flush = RUN & Q4 & br_pending.
- At the edge ending Q4 of RUN:
  - retired_count increments.
  - If sleep_req=1, the next state is SLEEP (q=0).
  - Otherwise, if br_pending=1, the next state is FLUSH.
  - Otherwise, the next state is RUN.
  - br_pending is kept when entering SLEEP and cleared in all other cases.
- At the edge ending Q4 of FLUSH, the next state is RUN. branch_req, sleep_req and periph_wait are ignored in FLUSH.
- SLEEP: `q` is frozen at 0 and all strobes are low. On the first edge with wake=1, the block leaves SLEEP:
  - to FLUSH if br_pending=1, clearing br_pending;
  - otherwise to RUN.
- Asserting rst at any time immediately forces the reset values. Any strobe in progress is truncated.

## Timing
- RUN cycle without stall: 4 clocks. Each stall clock adds 1, up to a maximum of 4+WAIT_MAX clocks.
- Taken branch: 8 clocks (the branch cycle followed by one FLUSH cycle).
- Startup: rst released before edge 1. Edges 1..RESET_HOLD_CLKS are in HOLD. FLUSH Q1 runs through edge RESET_HOLD_CLKS+4. The first RUN Q1 follows edge RESET_HOLD_CLKS+4.
- wr_strobe, instr_rd_en, pc_incr_en and instr_flush are each exactly 1 clock wide per cycle.
- SLEEP minimum duration is 1 clock, which occurs when wake is already high on entry.

## Test plan
- Reset with RESET_HOLD_CLKS=8:
  - q_phase=0 and all enables low for edges 1..8.
  - instr_rd_en high on clock 12.
  - exec_valid first rises after edge 12.
  - retired_count=0.
- Three straight-line RUN cycles, no requests → q_phase sequence 0,1,2,3 repeated; wr_strobe toggles with period 4; retired_count=3.
- branch_req=1 during Q3:
  - instr_flush pulses in Q4 of that cycle.
  - The next 4 clocks have exec_valid=0, rd_strobe=0, wr_strobe=0, instr_rd_en=1 in Q4.
  - retired_count does not count the flush cycle.
- periph_wait high for 3 clocks in Q2 → Q2 lasts 4 clocks, rd_strobe high throughout, bus_timeout=0. With periph_wait held for 20 clocks and WAIT_MAX=7 → Q2 lasts 8 clocks, then Q3; bus_timeout=1 and stays 1.
- sleep_req and branch_req both set in the same cycle:
  - SLEEP is entered and held for 10 clocks with wake=0.
  - Raising wake leads to a FLUSH cycle, then RUN.
  - retired_count increments once for the sleeping instruction.
- Assert rst during Q3 of a stalled RUN cycle → all outputs are at reset values before the next edge, and the HOLD sequence restarts.

Source files
------------

// File: rtl/q_cycle_sequencer_if.sv
// rtl/q_cycle_sequencer_if.sv - decoder/datapath signal bundle for the Q-cycle sequencer
//
// Requests (decoder side -> sequencer):
//   branch_req, sleep_req, wake, periph_wait
// Phase and strobes (sequencer -> datapath):
//   q_phase[1:0], exec_valid, rd_strobe, wr_strobe, instr_rd_en, pc_incr_en,
//   instr_flush, sleeping, bus_timeout, retired_count[15:0]
// master: the side that raises requests and consumes strobes.
// slave : the sequencer itself.

interface q_cycle_sequencer_if;
    logic        branch_req;
    logic        sleep_req;
    logic        wake;
    logic        periph_wait;
    logic [1:0]  q_phase;
    logic        exec_valid;
    logic        rd_strobe;
    logic        wr_strobe;
    logic        instr_rd_en;
    logic        pc_incr_en;
    logic        instr_flush;
    logic        sleeping;
    logic        bus_timeout;
    logic [15:0] retired_count;

    modport master (
        output branch_req, sleep_req, wake, periph_wait,
        input  q_phase, exec_valid, rd_strobe, wr_strobe, instr_rd_en,
               pc_incr_en, instr_flush, sleeping, bus_timeout, retired_count
    );

    modport slave (
        input  branch_req, sleep_req, wake, periph_wait,
        output q_phase, exec_valid, rd_strobe, wr_strobe, instr_rd_en,
               pc_incr_en, instr_flush, sleeping, bus_timeout, retired_count
    );
endinterface

// File: rtl/q_cycle_sequencer.sv
// rtl/q_cycle_sequencer.sv - four-phase instruction-cycle sequencer with flush, Q2 stall and sleep
//
// Ports:
//   clk  - core clock, rising edge
//   rst  - asynchronous active-low reset
//   bus  - q_cycle_sequencer_if.slave: requests in, phase/strobes/status out
// Parameters:
//   RESET_HOLD_CLKS - idle clocks after reset before the first flush cycle (1..255)
//   WAIT_MAX        - maximum Q2 stall clocks per instruction cycle (1..255)
// All outputs decode from registered state only.

module q_cycle_sequencer #(
    parameter int RESET_HOLD_CLKS = 8,
    parameter int WAIT_MAX        = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    q_cycle_sequencer_if.slave    bus
);

    localparam logic [1:0] ST_HOLD  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
    localparam logic [1:0] ST_SLEEP = 2'd3;

    localparam logic [7:0] HOLD_INIT  = 8'(RESET_HOLD_CLKS);
    localparam logic [7:0] WAIT_LIMIT = 8'(WAIT_MAX);

    logic [1:0]  state;
    logic [1:0]  q;
    logic [7:0]  hold_cnt;
    logic [7:0]  wait_cnt;
    logic        br_pending;
    logic        timeout_flag;
    logic [15:0] retired;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_HOLD;
            q            <= 2'd0;
            hold_cnt     <= HOLD_INIT;
            wait_cnt     <= 8'd0;
            br_pending   <= 1'b0;
            timeout_flag <= 1'b0;
            retired      <= 16'd0;
        end else begin
            case (state)
                ST_HOLD: begin
                    q <= 2'd0;
                    // Leave on the edge where the counter reaches zero.
                    if (hold_cnt <= 8'd1) begin
                        hold_cnt <= 8'd0;
                        state    <= ST_FLUSH;
                    end else begin
                        hold_cnt <= hold_cnt - 8'd1;
                    end
                end

                ST_RUN: begin
                    if (q == 2'd1 && bus.periph_wait && wait_cnt < WAIT_LIMIT) begin
                        // Stretch Q2 while the peripheral is not ready.
                        wait_cnt <= wait_cnt + 8'd1;
                    end else begin
                        wait_cnt <= 8'd0;
                        q        <= q + 2'd1;
                        // Still waiting with the budget spent: give up and flag it.
                        if (q == 2'd1 && bus.periph_wait)
                            timeout_flag <= 1'b1;
                        if (q == 2'd2)
                            br_pending <= bus.branch_req;
                        if (q == 2'd3) begin
                            retired <= retired + 16'd1;
                            if (bus.sleep_req) begin
                                // br_pending survives so the wake-up can flush.
                                state <= ST_SLEEP;
                            end else begin
                                br_pending <= 1'b0;
                                state      <= br_pending ? ST_FLUSH : ST_RUN;
                            end
                        end
                    end
                end

                ST_FLUSH: begin
                    q <= q + 2'd1;
                    if (q == 2'd3)
                        state <= ST_RUN;
                end

                ST_SLEEP: begin
                    q <= 2'd0;
                    if (bus.wake) begin
                        state      <= br_pending ? ST_FLUSH : ST_RUN;
                        br_pending <= 1'b0;
                    end
                end

                default: state <= ST_HOLD;
            endcase
        end
    end

    logic run_st;
    logic flush_st;
    assign run_st   = (state == ST_RUN);
    assign flush_st = (state == ST_FLUSH);

    assign bus.q_phase       = q;
    assign bus.exec_valid    = run_st;
    assign bus.rd_strobe     = run_st && (q == 2'd1);
    assign bus.wr_strobe     = run_st && (q == 2'd3);
    assign bus.instr_rd_en   = (run_st || flush_st) && (q == 2'd3);
    assign bus.pc_incr_en    = (run_st || flush_st) && (q == 2'd3);
    assign bus.instr_flush   = run_st && (q == 2'd3) && br_pending;
    assign bus.sleeping      = (state == ST_SLEEP);
    assign bus.bus_timeout   = timeout_flag;
    assign bus.retired_count = retired;

endmodule
